// File: rtl/dmem_port_ctrl_pkg.sv
// dmem_port_ctrl_pkg: shared state encoding and constants for the data-memory port controller.
package dmem_port_ctrl_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [31:0] TIMEOUT_RDATA = 32'h0;
endpackage

// File: rtl/dmem_timeout_cnt.sv
// dmem_timeout_cnt: saturating access-age counter; o_expire flags the last allowed cycle.
module dmem_timeout_cnt #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [W-1:0] MAX = W'(TIMEOUT_CYCLES);
    localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = i_clr ? '0 : (i_en && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // Compare with >= so an access that passes the limit after a late handshake is still bounded.
    assign o_expire = (TIMEOUT_CYCLES != 0) && i_en && (cnt_q >= LAST);
endmodule

// File: rtl/dmem_port_ctrl.sv
// dmem_port_ctrl: single-outstanding bridge from the memory stage to a valid/ready data memory.
module dmem_port_ctrl
    import dmem_port_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_req_addr,
    input  logic        i_req_ren,
    input  logic        i_req_wen,
    input  logic [31:0] i_req_wdata,
    input  logic [3:0]  i_req_mask,
    output logic        o_stall,
    output logic [31:0] o_rdata,
    output logic        o_rdata_valid,
    output logic        o_timeout,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    output logic [3:0]  o_mem_mask,
    input  logic        i_mem_rvalid,
    input  logic [31:0] i_mem_rdata
);
    state_e      state_q, state_d;
    logic [31:0] addr_q, wdata_q, rdata_q;
    logic [3:0]  mask_q;
    logic        wen_q, to_q;
    logic        req, launch, busy, complete, expire, timeout_hit;

    assign req         = i_req_ren | i_req_wen;
    assign launch      = (state_q == IDLE) && req;
    assign busy        = (state_q == REQ) || (state_q == RESP);
    assign complete    = ((state_q == REQ) && i_mem_ready) || ((state_q == RESP) && i_mem_rvalid);
    assign timeout_hit = busy && expire && !complete;

    dmem_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_cnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (launch),
        .i_en     (busy),
        .o_expire (expire)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = req ? REQ : IDLE;
            REQ:     state_d = i_mem_ready ? (wen_q ? DONE : RESP) : (expire ? DONE : REQ);
            RESP:    state_d = (i_mem_rvalid || expire) ? DONE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            mask_q  <= '0;
            wen_q   <= 1'b0;
            rdata_q <= '0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            to_q    <= timeout_hit;
            if (launch) begin
                addr_q  <= i_req_addr;
                wdata_q <= i_req_wdata;
                mask_q  <= i_req_mask;
                wen_q   <= i_req_wen;
            end
            if ((state_q == RESP) && i_mem_rvalid) rdata_q <= i_mem_rdata;
            else if (timeout_hit)                  rdata_q <= TIMEOUT_RDATA;
        end
    end

    assign o_stall       = (state_q == IDLE) ? req : (state_q != DONE);
    assign o_mem_valid   = (state_q == REQ);
    assign o_rdata_valid = (state_q == DONE) && !wen_q;
    assign o_timeout     = to_q;
    assign o_rdata       = rdata_q;
    assign o_mem_addr    = addr_q;
    assign o_mem_wen     = wen_q;
    assign o_mem_wdata   = wdata_q;
    assign o_mem_mask    = mask_q;
endmodule
